branch_predict_ctrl: RTL and testbench

Dynamic branch-direction predictor and redirect/flush controller for the 5-stage pipeline. It predicts conditional branches in Decode using a table of 2-bit saturating counters and requests an early redirect to the Decode-computed target. It compares each prediction against the Execute-stage branch-resolution signal `NeedBranchE`, raises a mispredict recovery (redirect plus flush), trains the table, and keeps performance counters.

---
 rtl/branch_predict_ctrl.sv | 166 ++++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit BHT branch predictor with redirect/flush control
//
// Predicts conditional branches in Decode from a table of 2-bit saturating
// counters, resolves the prediction in Execute, drives recovery redirects and
// pipeline flushes, trains the table and keeps two saturating perf counters.
//
// Ports:
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   PCD             Decode PC (indexes the table with PCD[IDX_W+1:2])
//   BranchD         Decode instruction is a conditional branch
//   StallD          Decode held by the hazard unit
//   FlushEIn        hazard-unit bubble request into Execute
//   BranchE         Execute instruction is a conditional branch
//   NeedBranchE     resolved branch outcome in Execute
//   PredTakenD      prediction for the Decode instruction
//   RedirectD       PC mux selects the Decode target
//   MispredictE     PC mux selects the recovery PC
//   RecoverSelE     recovery PC select: 1 = PC+4, 0 = branch target
//   FlushD          clear the Decode pipeline register
//   FlushE          clear the Execute pipeline register
//   BranchCount     resolved branch count (saturating)
//   MispredictCount mispredict count (saturating)

module branch_predict_ctrl #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] PCD,
  input  logic            BranchD,
  input  logic            StallD,
  input  logic            FlushEIn,
  input  logic            BranchE,
  input  logic            NeedBranchE,
  output logic            PredTakenD,
  output logic            RedirectD,
  output logic            MispredictE,
  output logic            RecoverSelE,
  output logic            FlushD,
  output logic            FlushE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredictCount
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Branch history table and Execute-stage prediction state.
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic             pred_taken_e_q;
  logic             pred_taken_e_d;
  logic [IDX_W-1:0] idx_e_q;
  logic [IDX_W-1:0] idx_e_d;
  logic [31:0]      branch_cnt_q;
  logic [31:0]      branch_cnt_d;
  logic [31:0]      mispredict_cnt_q;
  logic [31:0]      mispredict_cnt_d;

  logic [IDX_W-1:0] idx_dec;
  logic [1:0]       ctr_exe;
  logic [1:0]       ctr_trained;

  // Word-aligned PC: byte-offset bits and bits above the index are not used.
  logic unused_pcd;
  assign unused_pcd = ^{PCD[XLEN-1:IDX_W+2], PCD[1:0]};

  // ---------------------------------------------------------------------------
  // Decode: prediction and early redirect
  // ---------------------------------------------------------------------------
  assign idx_dec = PCD[IDX_W+1:2];

  // Plain read with no bypass: a same-cycle training write to this index is
  // only seen by the following cycle.
  assign PredTakenD = bht_q[idx_dec][1];

  // An Execute mispredict squashes whatever is in Decode, so it overrides any
  // Decode redirect.
  assign RedirectD = BranchD & PredTakenD & ~StallD & ~MispredictE;

  // ---------------------------------------------------------------------------
  // Execute: resolution and recovery
  // ---------------------------------------------------------------------------
  assign MispredictE = BranchE & (NeedBranchE ^ pred_taken_e_q);

  // Predicted taken but not taken -> fall through to PC+4; predicted
  // not-taken but taken -> go to the branch target.
  assign RecoverSelE = pred_taken_e_q;

  assign FlushD = RedirectD | MispredictE;
  assign FlushE = MispredictE | FlushEIn;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pred_taken_e_d = PredTakenD & BranchD;
    idx_e_d        = idx_dec;
    // A bubble or a squashed Decode slot enters Execute with no prediction.
    if (FlushEIn || MispredictE) begin
      pred_taken_e_d = 1'b0;
      idx_e_d        = '0;
    end
  end

  always_comb begin
    ctr_exe     = bht_q[idx_e_q];
    ctr_trained = ctr_exe;
    if (NeedBranchE) begin
      if (ctr_exe != CTR_ST) begin
        ctr_trained = ctr_exe + 2'd1;
      end
    end else begin
      if (ctr_exe != CTR_SNT) begin
        ctr_trained = ctr_exe - 2'd1;
      end
    end
  end

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (BranchE && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (MispredictE && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pred_taken_e_q   <= 1'b0;
      idx_e_q          <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      pred_taken_e_q   <= pred_taken_e_d;
      idx_e_q          <= idx_e_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Every entry starts weakly not-taken so one taken outcome flips it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_WNT;
      end
    end else if (BranchE) begin
      bht_q[idx_e_q] <= ctr_trained;
    end
  end

  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed bench for branch_predict_ctrl

module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] PCD;
  logic        BranchD;
  logic        StallD;
  logic        FlushEIn;
  logic        BranchE;
  logic        NeedBranchE;
  logic        PredTakenD;
  logic        RedirectD;
  logic        MispredictE;
  logic        RecoverSelE;
  logic        FlushD;
  logic        FlushE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int n_vec = 0;
  int n_err = 0;

  branch_predict_ctrl #(
    .XLEN        (32),
    .BHT_ENTRIES (64)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PCD             (PCD),
    .BranchD         (BranchD),
    .StallD          (StallD),
    .FlushEIn        (FlushEIn),
    .BranchE         (BranchE),
    .NeedBranchE     (NeedBranchE),
    .PredTakenD      (PredTakenD),
    .RedirectD       (RedirectD),
    .MispredictE     (MispredictE),
    .RecoverSelE     (RecoverSelE),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge, then settle.
  task automatic drive(input logic [31:0] pc, input logic brd, input logic stl,
                       input logic fl, input logic bre, input logic nb);
    @(negedge clk);
    PCD         = pc;
    BranchD     = brd;
    StallD      = stl;
    FlushEIn    = fl;
    BranchE     = bre;
    NeedBranchE = nb;
    #1;
  endtask

  initial begin
    // 0x40 -> index 16, 0x80 -> index 32, 0x100 and 0x200 -> index 0
    reset_n     = 1'b0;
    PCD         = 32'h40;
    BranchD     = 1'b1;
    StallD      = 1'b0;
    FlushEIn    = 1'b1;
    BranchE     = 1'b0;
    NeedBranchE = 1'b0;
    #2;
    check_eq("rst_pred",     {31'd0, PredTakenD},  32'd0);
    check_eq("rst_redirect", {31'd0, RedirectD},   32'd0);
    check_eq("rst_misp",     {31'd0, MispredictE}, 32'd0);
    check_eq("rst_recsel",   {31'd0, RecoverSelE}, 32'd0);
    check_eq("rst_flushd",   {31'd0, FlushD},      32'd0);
    check_eq("rst_flushe",   {31'd0, FlushE},      32'd1);
    check_eq("rst_bcnt",     BranchCount,          32'd0);
    check_eq("rst_mcnt",     MispredictCount,      32'd0);
    @(negedge clk);
    FlushEIn = 1'b0;
    BranchD  = 1'b0;
    #1;
    check_eq("rst_flushe_lo", {31'd0, FlushE}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Warm-up: index 16 goes 01 -> 10 -> 11
    drive(32'h40, 1, 0, 0, 0, 0);
    check_eq("wu_pred0",  {31'd0, PredTakenD}, 32'd0);
    check_eq("wu_redir0", {31'd0, RedirectD},  32'd0);
    drive(32'h100, 0, 0, 0, 1, 1);
    check_eq("wu_misp",   {31'd0, MispredictE}, 32'd1);
    check_eq("wu_recsel", {31'd0, RecoverSelE}, 32'd0);
    check_eq("wu_flushd", {31'd0, FlushD},      32'd1);
    check_eq("wu_flushe", {31'd0, FlushE},      32'd1);
    drive(32'h40, 1, 0, 0, 0, 0);
    check_eq("wu_pred1",  {31'd0, PredTakenD}, 32'd1);
    check_eq("wu_redir1", {31'd0, RedirectD},  32'd1);
    check_eq("wu_flushd_redir", {31'd0, FlushD}, 32'd1);
    drive(32'h100, 0, 0, 0, 1, 1);
    check_eq("wu_nomisp", {31'd0, MispredictE}, 32'd0);
    drive(32'h100, 0, 0, 0, 0, 0);
    check_eq("wu_bcnt", BranchCount,     32'd2);
    check_eq("wu_mcnt", MispredictCount, 32'd1);

    // Saturation at index 32: 5 taken, then 1 not-taken
    for (int i = 0; i < 5; i++) begin
      drive(32'h80, 1, 0, 0, 0, 0);
      check_eq("sat_pred", {31'd0, PredTakenD}, (i > 0) ? 32'd1 : 32'd0);
      drive(32'h100, 0, 0, 0, 1, 1);
      check_eq("sat_misp", {31'd0, MispredictE}, (i == 0) ? 32'd1 : 32'd0);
    end
    drive(32'h80, 1, 0, 0, 0, 0);
    check_eq("sat_ctr11",   {30'd0, dut.bht_q[32]}, 32'd3);
    check_eq("sat_pred_st", {31'd0, PredTakenD},    32'd1);
    drive(32'h100, 0, 0, 0, 1, 0);
    check_eq("sat_nt_misp",   {31'd0, MispredictE}, 32'd1);
    check_eq("sat_nt_recsel", {31'd0, RecoverSelE}, 32'd1);
    drive(32'h80, 1, 0, 0, 0, 0);
    check_eq("sat_ctr10",   {30'd0, dut.bht_q[32]}, 32'd2);
    check_eq("sat_pred_wt", {31'd0, PredTakenD},    32'd1);
    check_eq("sat_bcnt", BranchCount,     32'd8);
    check_eq("sat_mcnt", MispredictCount, 32'd3);

    // Priority: Decode predicts taken (index 16) while Execute mispredicts (index 0)
    drive(32'h200, 1, 0, 0, 0, 0);
    check_eq("pri_setup_pred", {31'd0, PredTakenD}, 32'd0);
    drive(32'h40, 1, 0, 0, 1, 1);
    check_eq("pri_pred",   {31'd0, PredTakenD},  32'd1);
    check_eq("pri_redir",  {31'd0, RedirectD},   32'd0);
    check_eq("pri_misp",   {31'd0, MispredictE}, 32'd1);
    check_eq("pri_flushd", {31'd0, FlushD},      32'd1);
    drive(32'h100, 0, 0, 0, 0, 0);
    check_eq("pri_pte_clr", {31'd0, dut.pred_taken_e_q}, 32'd0);
    check_eq("pri_bcnt", BranchCount,     32'd9);
    check_eq("pri_mcnt", MispredictCount, 32'd4);

    // Stall then release of a predicted-taken branch
    drive(32'h40, 1, 1, 0, 0, 0);
    check_eq("st_redir0", {31'd0, RedirectD}, 32'd0);
    drive(32'h40, 1, 1, 0, 0, 0);
    check_eq("st_redir1", {31'd0, RedirectD}, 32'd0);
    drive(32'h40, 1, 0, 0, 0, 0);
    check_eq("st_redir_rel", {31'd0, RedirectD}, 32'd1);

    // Bubble: clears the Execute prediction, no training or counting
    drive(32'h100, 0, 0, 1, 0, 0);
    check_eq("bub_pte_pre", {31'd0, dut.pred_taken_e_q}, 32'd1);
    check_eq("bub_flushe",  {31'd0, FlushE},      32'd1);
    check_eq("bub_misp",    {31'd0, MispredictE}, 32'd0);
    drive(32'h100, 0, 0, 0, 0, 0);
    check_eq("bub_pte",  {31'd0, dut.pred_taken_e_q}, 32'd0);
    check_eq("bub_bcnt", BranchCount,     32'd9);
    check_eq("bub_mcnt", MispredictCount, 32'd4);

    // Counter saturation from 0xFFFFFFFE, three mispredicted resolutions
    @(negedge clk);
    force dut.branch_cnt_q     = 32'hFFFF_FFFE;
    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt_q;
    release dut.mispredict_cnt_q;
    #1;
    check_eq("cs_preload", BranchCount, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 0, 0, 0, 1, 1);
      check_eq("cs_misp", {31'd0, MispredictE}, 32'd1);
      check_eq("cs_bcnt_run", BranchCount, (i == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
    drive(32'h100, 0, 0, 0, 0, 0);
    check_eq("cs_bcnt", BranchCount,     32'hFFFF_FFFF);
    check_eq("cs_mcnt", MispredictCount, 32'hFFFF_FFFF);

    // Mid-run reset with a taken prediction pending in Execute
    drive(32'h40, 1, 0, 0, 0, 0);
    check_eq("mr_pred_pre", {31'd0, PredTakenD}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mr_pte",   {31'd0, dut.pred_taken_e_q}, 32'd0);
    check_eq("mr_pred",  {31'd0, PredTakenD},  32'd0);
    check_eq("mr_redir", {31'd0, RedirectD},   32'd0);
    check_eq("mr_flushd", {31'd0, FlushD},     32'd0);
    check_eq("mr_bcnt",  BranchCount,          32'd0);
    check_eq("mr_mcnt",  MispredictCount,      32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(32'h40, 1, 0, 0, 0, 0);
    check_eq("mr_first_pred", {31'd0, PredTakenD}, 32'd0);
    check_eq("mr_first_misp", {31'd0, MispredictE}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
